ipsl_pcie_dma_mwr_tx: RTL and testbench
=======================================

Name: ipsl_pcie_dma_mwr_tx

Overview:
- Memory-write TLP transmitter directly downstream of the DMA read-control stage.
- Accepts one DMA write command at a time and drives that stage's read request (enable, length, local address).
- Emits a 3DW/4DW MWr header beat on the 128-bit AXI-stream TX interface of the PCIe core, then forwards the prefetched payload beats, popping them through the tlp_tx/tx_hold handshake.

Parameters:
MAX_PAYLOAD_DW, 10'd128, largest legal payload in DW (Max Payload Size); longer commands are rejected.

Ports:
clk  in  1  user clock (gen1 62.5MHz, gen2 125MHz)
rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&&ready
i_cmd_pcie_addr  in  64  PCIe destination byte address, DW aligned
i_cmd_local_addr  in  64  local BAR RAM byte address
i_cmd_length  in  10  payload length in DW, legal 1..MAX_PAYLOAD_DW
i_req_id  in  16  requester ID {bus,dev,func}
o_rd_en  out  1  read-stage enable; rising edge starts a read
o_rd_length  out  10  latched command length
o_rd_addr  out  64  latched local address
i_gen_tlp_start  in  1  read-stage payload beat available
i_rd_data  in  128  read-stage payload beat, DW0 in [31:0]
i_last_data  in  1  read-stage flag: current pop is the final beat
o_tlp_tx  out  1  payload phase active
o_tx_hold  out  1  core back-pressure (=~i_axis_tready)
o_axis_tvalid  out  1  TX stream valid
i_axis_tready  in  1  TX stream ready
o_axis_tdata  out  128  TX stream data
o_axis_tkeep  out  4  per-DW valid mask
o_axis_tlast  out  1  final beat of TLP
o_busy  out  1  high outside IDLE
o_done  out  1  one-cycle pulse, TLP fully sent
o_err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset: all outputs 0, FSM=IDLE, tag=8'h00, latched fields 0; o_tx_hold = ~i_axis_tready at all times.
- FSM states: IDLE, CHECK, WAIT_DATA, HDR, DATA, GAP.
- IDLE:
  - o_cmd_ready=1.
  - On handshake: latch pcie_addr, local_addr, length, req_id; go to CHECK.
- CHECK (1 cycle):
  - Reject if length==0, or length>MAX_PAYLOAD_DW, or {1'b0,pcie_addr[11:2]}+length>11'd1024 (4KB crossing).
  - On reject: o_err pulse, go to IDLE.
  - Otherwise: go to WAIT_DATA.
- WAIT_DATA:
  - o_rd_en=1; held high through DATA.
  - Go to HDR when i_gen_tlp_start=1; no TX traffic until then.
- HDR:
  - o_axis_tvalid=1, tlast=0, o_tlp_tx=0.
  - Fmt: 3'b011 (4DW) if pcie_addr[63:32]!=0, else 3'b010 (3DW). Type 5'b00000; TC/attr/TD/EP=0; length=latched length.
  - DW0 = {fmt,type,1'b0,3'b0,4'b0,1'b0,1'b0,2'b0,2'b0,length}.
  - DW1 = {req_id,tag,lastBE,4'hF}; lastBE=4'h0 if length==1, else 4'hF.
  - 4DW: DW2=addr[63:32], DW3={addr[31:2],2'b00}, tkeep=4'hF.
  - 3DW: DW2={addr[31:2],2'b00}, DW3=0, tkeep=4'h7.
  - Hold stable until i_axis_tready, then go to DATA.
- DATA:
  - o_tlp_tx=1; o_axis_tvalid=i_gen_tlp_start; tdata=i_rd_data.
  - The read stage pops when o_tlp_tx && ~o_tx_hold; a beat transfers when tvalid&&tready.
  - Remaining-DW counter loads length at HDR exit; decrements by 4 per transfer, saturating at 0.
  - tkeep=4'hF while remaining>4, else mask of remaining DW (1→4'h1, 2→4'h3, 3→4'h7, 4→4'hF).
  - tlast=i_last_data; it must coincide with remaining<=4. A mismatch is a protocol violation covered by an assertion, not by recovery logic.
  - Transfer with tlast → GAP.
- GAP (1 cycle):
  - o_rd_en=0, guaranteeing a rising edge for the next command.
  - o_done pulse; tag increments (8-bit wrap FF→00); go to IDLE.
- Bubbles: gen_tlp_start low during DATA gives tvalid=0; the header is never resent.
- Back-pressure: tdata/tkeep/tlast stay stable while tvalid&&!tready (header: registered; data: read stage does not pop).
- Latency: command handshake to header tvalid ≥ 2 cycles plus read-stage fill; header-to-first-data ≥ 1 cycle.
- rst_n low mid-TLP: immediate return to reset values; a partial TLP is abandoned; the tag returns to 0.

Test Plan:
- 3DW, length=8, pcie_addr=0x0000_0000_1000_0040, tag=0, tready=1 → header tkeep=4'h7, DW0=0x4000_0008, DW1={req_id,8'h00,4'hF,4'hF}, DW2=0x1000_0040; then 2 data beats tkeep F,F; tlast on beat 2; o_done; next tag=1.
- 4DW, length=5, addr=0x1_0000_0100 → DW0=0x6000_0005, DW2=0x0000_0001, DW3=0x0000_0100; data beats tkeep F then 1; tlast on 2nd.
- length=1 → DW1 BE byte=8'h0F; single data beat, tkeep=4'h1, tlast=1.
- length=129 (MAX=128), or addr[11:0]=0xFF0 with length=8 → o_err pulse, o_rd_en never rises, o_cmd_ready back to 1 after 2 cycles.
- Random tready toggling and gen_tlp_start gaps, length=64 → 1 header + 16 data beats, no duplicated/lost beat, data stable under stall.
- 256 back-to-back commands → o_rd_en low ≥1 cycle between each; tag wraps FF→00; rst_n asserted mid-DATA → all outputs 0 next edge.

Source files
------------

// File: rtl/ipsl_pcie_dma_mwr_tx.sv
// Memory-write TLP transmitter: takes one DMA write command, drives the read
// stage request, then emits a 3DW/4DW MWr header followed by the payload beats.
module ipsl_pcie_dma_mwr_tx #(
  parameter logic [9:0] MAX_PAYLOAD_DW = 10'd128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [63:0]  i_cmd_pcie_addr,
  input  logic [63:0]  i_cmd_local_addr,
  input  logic [9:0]   i_cmd_length,
  input  logic [15:0]  i_req_id,
  output logic         o_rd_en,
  output logic [9:0]   o_rd_length,
  output logic [63:0]  o_rd_addr,
  input  logic         i_gen_tlp_start,
  input  logic [127:0] i_rd_data,
  input  logic         i_last_data,
  output logic         o_tlp_tx,
  output logic         o_tx_hold,
  output logic         o_axis_tvalid,
  input  logic         i_axis_tready,
  output logic [127:0] o_axis_tdata,
  output logic [3:0]   o_axis_tkeep,
  output logic         o_axis_tlast,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT_DATA, S_HDR, S_DATA, S_GAP
  } state_t;

  state_t       state_q, state_d;
  logic [63:2]  addr_q, addr_d;
  logic [63:0]  local_q, local_d;
  logic [9:0]   len_q, len_d;
  logic [9:0]   rem_q, rem_d;
  logic [15:0]  req_q, req_d;
  logic [7:0]   tag_q, tag_d;
  logic         cmd_ready_c;

  // Destination address is DW aligned, so the two byte-offset bits carry nothing.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_cmd_pcie_addr[1:0];

  logic [10:0]  end_dw;
  logic         reject;
  logic         is_4dw;
  logic [31:0]  hdr_dw0, hdr_dw1;
  logic [127:0] hdr_data;
  logic [3:0]   data_keep;

  // A TLP may not run past the 4KB page that contains its start address.
  assign end_dw = {1'b0, addr_q[11:2]} + {1'b0, len_q};
  assign reject = (len_q == 10'd0) || (len_q > MAX_PAYLOAD_DW) || (end_dw > 11'd1024);

  assign is_4dw  = |addr_q[63:32];
  assign hdr_dw0 = {(is_4dw ? 3'b011 : 3'b010), 5'b00000, 1'b0, 3'b000, 4'b0000,
                    1'b0, 1'b0, 2'b00, 2'b00, len_q};
  assign hdr_dw1 = {req_q, tag_q, ((len_q == 10'd1) ? 4'h0 : 4'hF), 4'hF};
  assign hdr_data = is_4dw ? {addr_q[31:2], 2'b00, addr_q[63:32], hdr_dw1, hdr_dw0}
                           : {32'h0, addr_q[31:2], 2'b00, hdr_dw1, hdr_dw0};

  always_comb begin
    case (rem_q)
      10'd1:   data_keep = 4'h1;
      10'd2:   data_keep = 4'h3;
      10'd3:   data_keep = 4'h7;
      default: data_keep = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      local_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      req_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      local_q <= local_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    local_d       = local_q;
    len_d         = len_q;
    rem_d         = rem_q;
    req_d         = req_q;
    tag_d         = tag_q;
    cmd_ready_c   = 1'b0;
    o_rd_en       = 1'b0;
    o_tlp_tx      = 1'b0;
    o_axis_tvalid = 1'b0;
    o_axis_tdata  = '0;
    o_axis_tkeep  = '0;
    o_axis_tlast  = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (i_cmd_valid) begin
          addr_d  = i_cmd_pcie_addr[63:2];
          local_d = i_cmd_local_addr;
          len_d   = i_cmd_length;
          req_d   = i_req_id;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          o_err   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        o_rd_en = 1'b1;
        if (i_gen_tlp_start) state_d = S_HDR;
      end
      S_HDR: begin
        o_rd_en       = 1'b1;
        o_axis_tvalid = 1'b1;
        o_axis_tdata  = hdr_data;
        o_axis_tkeep  = is_4dw ? 4'hF : 4'h7;
        if (i_axis_tready) begin
          rem_d   = len_q;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Read stage pops on tlp_tx && ~tx_hold, so an unpopped beat stays put.
        o_rd_en       = 1'b1;
        o_tlp_tx      = 1'b1;
        o_axis_tvalid = i_gen_tlp_start;
        o_axis_tdata  = i_rd_data;
        o_axis_tkeep  = data_keep;
        o_axis_tlast  = i_last_data;
        if (i_gen_tlp_start && i_axis_tready) begin
          rem_d = (rem_q > 10'd4) ? (rem_q - 10'd4) : 10'd0;
          if (i_last_data) state_d = S_GAP;
        end
      end
      S_GAP: begin
        o_done  = 1'b1;
        tag_d   = tag_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated so every output reads 0 while reset is held.
  assign o_cmd_ready = cmd_ready_c & rst_n;
  assign o_tx_hold   = ~i_axis_tready;
  assign o_busy      = (state_q != S_IDLE);
  assign o_rd_length = len_q;
  assign o_rd_addr   = local_q;

  // The read stage's last-beat flag must line up with the DW count.
  a_last_matches_len: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_DATA && i_gen_tlp_start && i_axis_tready) |-> (i_last_data == (rem_q <= 10'd4))
  );

endmodule

// File: tb/tb_ipsl_pcie_dma_mwr_tx.sv
// Bench for ipsl_pcie_dma_mwr_tx: random commands, a read-stage model feeding
// payload, random back-pressure, and a scoreboard of expected TX beats/events.
module tb_ipsl_pcie_dma_mwr_tx;
  localparam int W = 133;  // {tdata, tkeep, tlast}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_cmd_valid = 1'b0;
  logic         o_cmd_ready;
  logic [63:0]  i_cmd_pcie_addr = '0;
  logic [63:0]  i_cmd_local_addr = '0;
  logic [9:0]   i_cmd_length = '0;
  logic [15:0]  i_req_id = '0;
  logic         o_rd_en;
  logic [9:0]   o_rd_length;
  logic [63:0]  o_rd_addr;
  logic         i_gen_tlp_start;
  logic [127:0] i_rd_data;
  logic         i_last_data;
  logic         o_tlp_tx;
  logic         o_tx_hold;
  logic         o_axis_tvalid;
  logic         i_axis_tready;
  logic [127:0] o_axis_tdata;
  logic [3:0]   o_axis_tkeep;
  logic         o_axis_tlast;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  always #5 clk = ~clk;

  ipsl_pcie_dma_mwr_tx dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_pcie_addr(i_cmd_pcie_addr), .i_cmd_local_addr(i_cmd_local_addr),
    .i_cmd_length(i_cmd_length), .i_req_id(i_req_id),
    .o_rd_en(o_rd_en), .o_rd_length(o_rd_length), .o_rd_addr(o_rd_addr),
    .i_gen_tlp_start(i_gen_tlp_start), .i_rd_data(i_rd_data), .i_last_data(i_last_data),
    .o_tlp_tx(o_tlp_tx), .o_tx_hold(o_tx_hold),
    .o_axis_tvalid(o_axis_tvalid), .i_axis_tready(i_axis_tready),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep), .o_axis_tlast(o_axis_tlast),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [1:0]    evt_q[$];      // 2'b01 done, 2'b10 err
  logic [127:0]  src_q[$];      // payload beats the read stage will serve
  int            src_cnt_q[$];  // beats per accepted command
  logic [73:0]   rdcmd_q[$];    // {local_addr, length} expected on rd_en rise
  logic [7:0]    tag_m = 8'h00;
  int            n_checks = 0;
  int            n_pass = 0;
  bit            gaps_on = 0;
  bit            rand_ready = 0;
  bit            flush = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: got %s expected otherwise", name, what);
  endtask

  // Reference model: what the TX stream should carry for one accepted command.
  task automatic model_cmd(input logic [63:0] pa, input logic [63:0] la, input int len,
                           input logic [15:0] rid);
    int off, nb, rem;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic [3:0] keep;
    logic [127:0] data;
    off = int'(pa[11:2]);
    if (len < 1 || len > 128 || off + len > 1024) begin
      evt_q.push_back(2'b10);
      return;
    end
    dw0 = {((pa[63:32] != 32'h0) ? 8'h60 : 8'h40), 14'h0, len[9:0]};
    dw1 = {rid, tag_m, ((len == 1) ? 4'h0 : 4'hF), 4'hF};
    if (pa[63:32] != 32'h0) begin
      dw2 = pa[63:32]; dw3 = {pa[31:2], 2'b00}; keep = 4'hF;
    end else begin
      dw2 = {pa[31:2], 2'b00}; dw3 = 32'h0; keep = 4'h7;
    end
    exp_q.push_back({dw3, dw2, dw1, dw0, keep, 1'b0});
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      rem = len - 4 * b;
      keep = (rem >= 4) ? 4'hF : (4'hF >> (4 - rem));
      src_q.push_back(data);
      exp_q.push_back({data, keep, (b == nb - 1)});
    end
    src_cnt_q.push_back(nb);
    rdcmd_q.push_back({la, len[9:0]});
    evt_q.push_back(2'b01);
    tag_m++;
  endtask

  task automatic send_cmd(input logic [63:0] pa, input logic [63:0] la, input int len,
                          input logic [15:0] rid);
    int t = 0;
    bit hs = 0;
    i_cmd_valid = 1'b1;
    i_cmd_pcie_addr = pa;
    i_cmd_local_addr = la;
    i_cmd_length = len[9:0];
    i_req_id = rid;
    while (!hs) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        hs = 1;
        check("rd_en_low_at_accept", o_rd_en, 0);
        model_cmd(pa, la, len, rid);
      end else if (++t > 5000) begin
        fail_now("cmd_accept_timeout", "no o_cmd_ready");
        hs = 1;
      end
      @(posedge clk); #1;
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic err_cmd(input logic [63:0] pa, input int len);
    send_cmd(pa, 64'h55, len, 16'h0001);
    @(negedge clk);
    check("err_ready_in_check", o_cmd_ready, 0);
    @(negedge clk);
    check("err_ready_back", o_cmd_ready, 1);
    check("err_rd_en_idle", o_rd_en, 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_cmd(input bit allow_bad, input int maxlen);
    logic [63:0] pa;
    int len, off;
    len = $urandom_range(1, maxlen);
    off = $urandom_range(0, 1024 - len);
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 2))
        0: len = 0;
        1: len = $urandom_range(129, 1023);
        default: begin
          len = $urandom_range(2, 128);
          off = $urandom_range(1025 - len, 1023);
        end
      endcase
    end
    pa = {(($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0), 20'($urandom), off[9:0], 2'b00};
    send_cmd(pa, {$urandom, $urandom}, len, 16'($urandom));
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 || evt_q.size() != 0 || !o_cmd_ready) begin
      @(negedge clk);
      if (++t > budget) begin
        fail_now("drain_timeout", $sformatf("%0d beats %0d events left", exp_q.size(), evt_q.size()));
        exp_q.delete();
        evt_q.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Back-pressure driver
  initial begin
    i_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Read-stage model: loads a command's beats on o_rd_en rise, pops on tlp_tx && ~tx_hold.
  initial begin
    logic [127:0] cur[$];
    bit avail = 0, prev_en = 0, en_now, pop;
    int nb;
    i_gen_tlp_start = 1'b0;
    i_rd_data = '0;
    i_last_data = 1'b0;
    forever begin
      @(negedge clk);
      en_now = o_rd_en;
      pop = o_tlp_tx && !o_tx_hold && i_gen_tlp_start;
      if (rst_n && en_now && !prev_en) begin
        if (rdcmd_q.size() == 0 || src_cnt_q.size() == 0) begin
          fail_now("rd_en_unexpected", "rising o_rd_en");
        end else begin
          check("rd_cmd", {o_rd_addr, o_rd_length}, rdcmd_q.pop_front());
          nb = src_cnt_q.pop_front();
          for (int i = 0; i < nb; i++) cur.push_back(src_q.pop_front());
        end
      end
      @(posedge clk); #1;
      if (flush) begin
        cur.delete(); avail = 0; en_now = 0; pop = 0;
      end
      if (pop && cur.size() > 0) begin
        void'(cur.pop_front());
        avail = 0;
      end
      prev_en = en_now;
      if (!avail && cur.size() > 0) avail = gaps_on ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (cur.size() == 0) avail = 0;
      i_gen_tlp_start = avail;
      i_rd_data = avail ? cur[0] : '0;
      i_last_data = avail && (cur.size() == 1);
    end
  end

  // Monitor: compares every transferred beat and every done/err pulse.
  initial begin
    logic [W-1:0] got, stall_v;
    logic [1:0] ev;
    logic exp_hold;
    bit stalled = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        continue;
      end
      exp_hold = !i_axis_tready;
      check("tx_hold", o_tx_hold, exp_hold);
      got = {o_axis_tdata, o_axis_tkeep, o_axis_tlast};
      if (stalled) begin
        check("stall_tvalid_held", o_axis_tvalid, 1);
        check("stall_stable", got, stall_v);
      end
      stalled = 0;
      if (o_axis_tvalid) begin
        if (i_axis_tready) begin
          if (exp_q.size() == 0) fail_now("beat_unexpected", $sformatf("%h", got));
          else check("beat", got, exp_q.pop_front());
        end else begin
          stalled = 1;
          stall_v = got;
        end
      end
      if (o_done || o_err) begin
        ev = {o_err, o_done};
        if (evt_q.size() == 0) fail_now("event_unexpected", $sformatf("%b", ev));
        else check("event", ev, evt_q.pop_front());
        if (o_err) check("rd_en_on_err", o_rd_en, 0);
      end
    end
  end

  task automatic check_all_zero(input string name);
    logic exp_hold;
    exp_hold = !i_axis_tready;
    check({name, "_ctrl"}, {o_cmd_ready, o_rd_en, o_tlp_tx, o_axis_tvalid, o_axis_tlast,
                            o_busy, o_done, o_err}, 0);
    check({name, "_data"}, {o_axis_tkeep, o_axis_tdata}, 0);
    check({name, "_latched"}, {o_rd_length, o_rd_addr}, 0);
    check({name, "_tx_hold"}, o_tx_hold, exp_hold);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", o_cmd_ready, 1);
    @(posedge clk); #1;

    // Directed cases
    send_cmd(64'h0000_0000_1000_0040, 64'h0000_0000_0000_0100, 8, 16'h0108);
    wait_drain(500);
    send_cmd(64'h0000_0001_0000_0100, 64'h0000_0000_0000_0200, 5, 16'h0210);
    wait_drain(500);
    send_cmd(64'h0000_0000_2000_0000, 64'h0000_0000_0000_0300, 1, 16'h0318);
    wait_drain(500);
    err_cmd(64'h0000_0000_2000_0000, 129);
    err_cmd(64'h0000_0000_3000_0FF0, 8);
    err_cmd(64'h0000_0000_3000_0000, 0);
    send_cmd(64'h0000_0000_3000_0FE0, 64'h0000_0000_0000_0400, 8, 16'h0420);
    wait_drain(500);
    send_cmd(64'h0000_0000_4000_0000, 64'h0000_0000_0000_0500, 128, 16'h0528);
    wait_drain(2000);

    // Random back-pressure and read-stage bubbles
    gaps_on = 1;
    rand_ready = 1;
    send_cmd(64'h0000_0000_5000_0100, 64'h0000_0000_0000_0600, 64, 16'h0630);
    wait_drain(2000);
    for (int i = 0; i < 30; i++) begin
      rand_cmd(1, 128);
      wait_drain(3000);
    end

    // Back-to-back commands; tag wraps
    for (int i = 0; i < 256; i++) rand_cmd(i % 16 == 5, 8);
    wait_drain(20000);

    // Reset in the middle of a payload
    gaps_on = 0;
    rand_ready = 0;
    send_cmd(64'h0000_0000_6000_0000, 64'h0000_0000_0000_0700, 64, 16'h0738);
    t = 0;
    while (!o_tlp_tx) begin
      @(negedge clk);
      if (++t > 500) begin
        fail_now("reach_data_timeout", "o_tlp_tx low");
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    flush = 1;
    repeat (3) @(posedge clk);
    #2;
    flush = 0;
    exp_q.delete();
    evt_q.delete();
    src_q.delete();
    src_cnt_q.delete();
    rdcmd_q.delete();
    tag_m = 8'h00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(64'h0000_0000_7000_0010, 64'h0000_0000_0000_0800, 4, 16'h0840);
    wait_drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
